dict_decompressor: RTL

//  Stage-1 dictionary decompressor, the inverse of the compressor's comparator/max-selector path.
//  - Input: one {type, location, literal} code per handshake.
//  - Output: the reconstructed 32-bit word.
//  - Keeps a FIFO-replacement dictionary that mirrors the compressor's update rule, so both ends stay in sync.

---
 rtl/dict_decompressor.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dict_decompressor.sv
// dict_decompressor: stage-1 dictionary decompressor (inverse of the compressor's match selector).
// Latency 1 cycle from code acceptance to o_valid/o_data. Single output register with
// o_ready = !o_valid || i_ready, which gives full throughput while downstream keeps i_ready high.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_clear                sync flush of the dictionary state and the error flag
//   i_valid/o_ready        code handshake: i_type, i_location, i_literal
//   o_valid/i_ready        word handshake: o_data
//   o_fill, o_err          valid-entry count (saturating) and sticky invalid-reference flag
//   o_word_cnt, o_hit_cnt  output statistics
//
// Optional feature macro: DECOMP_STATS_EN. When it is undefined, both counters are tied to 0.
module dict_decompressor #(
  parameter int INPUT_WORD = 32,
  parameter int DICT_ENTRY = 16,
  parameter int DICT_WORD  = 32,
  localparam int LOC_W     = $clog2(DICT_ENTRY),
  localparam int FILL_W    = LOC_W + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_type,
  input  logic [LOC_W-1:0]      i_location,
  input  logic [INPUT_WORD-1:0] i_literal,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INPUT_WORD-1:0] o_data,
  output logic [FILL_W-1:0]     o_fill,
  output logic                  o_err,
  output logic [31:0]           o_word_cnt,
  output logic [31:0]           o_hit_cnt
);

  logic [DICT_WORD-1:0]  dict_mem [DICT_ENTRY];
  logic [DICT_ENTRY-1:0] entry_vld;
  logic [LOC_W-1:0]      wr_ptr;
  logic [DICT_WORD-1:0]  dict_rd;
  logic [INPUT_WORD-1:0] recon;
  logic                  accept;
  logic                  dict_upd;
  logic                  bad_ref;

  // Clear blocks acceptance so that a flush never races with a dictionary write.
  assign o_ready  = !i_clear && (!o_valid || i_ready);
  assign accept   = i_valid && o_ready;
  assign dict_upd = accept && (i_type != 2'b11);
  assign bad_ref  = accept && (i_type != 2'b00) && !entry_vld[i_location];

  // Invalid entries read as zero, so stale data left behind by a clear or reset never leaks out.
  always_comb begin
    dict_rd = '0;
    if (entry_vld[i_location]) dict_rd = dict_mem[i_location];
  end

  always_comb begin
    recon = i_literal;
    case (i_type)
      2'b00: recon = i_literal;
      2'b01: recon = {dict_rd[INPUT_WORD-1:16], i_literal[15:0]};
      2'b10: recon = {dict_rd[INPUT_WORD-1:8], i_literal[7:0]};
      2'b11: recon = dict_rd;
      default: recon = i_literal;
    endcase
  end

  // Dictionary storage needs no reset: entry_vld gates every read.
  always_ff @(posedge i_clk) begin
    if (dict_upd) dict_mem[wr_ptr] <= recon;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_fill    <= '0;
      o_err     <= 1'b0;
      wr_ptr    <= '0;
      entry_vld <= '0;
    end else begin
      // The output register advances independently of a clear: a held word stays until it is taken.
      if (accept) begin
        o_valid <= 1'b1;
        o_data  <= recon;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end

      if (i_clear) begin
        o_fill    <= '0;
        o_err     <= 1'b0;
        wr_ptr    <= '0;
        entry_vld <= '0;
      end else begin
        if (bad_ref) o_err <= 1'b1;
        if (dict_upd) begin
          entry_vld[wr_ptr] <= 1'b1;
          wr_ptr            <= wr_ptr + 1'b1;  // power-of-two depth wraps naturally
          if (o_fill != FILL_W'(DICT_ENTRY)) o_fill <= o_fill + 1'b1;
        end
      end
    end
  end

`ifdef DECOMP_STATS_EN
  logic out_hit;
  logic out_hs;

  assign out_hs = o_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_hit    <= 1'b0;
      o_word_cnt <= '0;
      o_hit_cnt  <= '0;
    end else begin
      if (accept) out_hit <= (i_type == 2'b11);
      if (i_clear) begin
        o_word_cnt <= '0;
        o_hit_cnt  <= '0;
      end else if (out_hs) begin
        o_word_cnt <= o_word_cnt + 32'd1;
        if (out_hit) o_hit_cnt <= o_hit_cnt + 32'd1;
      end
    end
  end
`else
  assign o_word_cnt = '0;
  assign o_hit_cnt  = '0;
`endif

endmodule
